// File: rtl/qed_issue_sequencer.sv
// Issue sequencer for the SQED harness: forwards original instructions to the core while caching them,
// then replays the cached words as duplicates. It also tracks commits to flag a consistency checkpoint.
module qed_issue_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec_dup,
  input  logic               ifu_valid,
  input  logic [INSTR_W-1:0] ifu_instr,
  output logic               ifu_ready,
  output logic               core_valid,
  output logic [INSTR_W-1:0] core_instr,
  output logic               core_is_dup,
  input  logic               core_ready,
  input  logic               commit_valid,
  input  logic               commit_is_dup,
  output logic [CNT_W-1:0]   qed_num_orig,
  output logic [CNT_W-1:0]   qed_num_dup,
  output logic               qed_mode,
  output logic               qed_ready,
  output logic               q_full,
  output logic               q_empty
);

  typedef enum logic {S_ORIG = 1'b0, S_DUP = 1'b1} state_e;

  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   cache_q [DEPTH];
  logic [ADDR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [CNT_W-1:0]     iss_orig_q, iss_orig_d, iss_dup_q, iss_dup_d;
  logic [CNT_W-1:0]     num_orig_q, num_orig_d, num_dup_q, num_dup_d;
  logic                 ready_q, ready_d;
  logic                 push, pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  assign q_full       = (count_q == FULL_CNT);
  assign q_empty      = (count_q == '0);
  assign qed_mode     = (state_q == S_DUP);
  assign qed_num_orig = num_orig_q;
  assign qed_num_dup  = num_dup_q;
  assign qed_ready    = ready_q;

  always_comb begin
    state_d     = state_q;
    ifu_ready   = 1'b0;
    core_valid  = 1'b0;
    core_instr  = ifu_instr;
    core_is_dup = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    if (state_q == S_ORIG) begin
      core_valid = ifu_valid & ~q_full;
      ifu_ready  = core_ready & ~q_full;
      push       = ifu_valid & core_ready & ~q_full;
    end else begin
      core_valid  = ~q_empty;
      core_instr  = cache_q[head_q];
      core_is_dup = 1'b1;
      pop         = ~q_empty & core_ready;
    end

    head_d     = pop  ? head_q + ADDR_W'(1) : head_q;
    tail_d     = push ? tail_q + ADDR_W'(1) : tail_q;
    count_d    = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    iss_orig_d = sat_inc(iss_orig_q, push);
    iss_dup_d  = sat_inc(iss_dup_q, pop);

    // A same-cycle push is already in count_d, so it is replayed too.
    if (state_q == S_ORIG) begin
      if ((count_d != '0) && (exec_dup || (count_d == FULL_CNT))) state_d = S_DUP;
    end else if (count_d == '0) begin
      state_d = S_ORIG;
    end

    num_orig_d = sat_inc(num_orig_q, commit_valid & ~commit_is_dup);
    num_dup_d  = sat_inc(num_dup_q, commit_valid & commit_is_dup);

    ready_d = (state_d == S_ORIG) && (count_d == '0) &&
              (num_orig_d == num_dup_d) && (num_orig_d != '0) &&
              (num_orig_d == iss_orig_d) && (num_dup_d == iss_dup_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ORIG;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      iss_orig_q <= '0;
      iss_dup_q  <= '0;
      num_orig_q <= '0;
      num_dup_q  <= '0;
      ready_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) cache_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      iss_orig_q <= iss_orig_d;
      iss_dup_q  <= iss_dup_d;
      num_orig_q <= num_orig_d;
      num_dup_q  <= num_dup_d;
      ready_q    <= ready_d;
      if (push) cache_q[tail_q] <= ifu_instr;
    end
  end

endmodule

// File: doc/qed_issue_sequencer.md
Name: qed_issue_sequencer

Overview:
- Sequences original and duplicate instruction issue for the SQED harness around the picorv32 core.
- Sits between the instruction-fetch path and the core decode input.
- In ORIG mode it forwards fetched original instructions to the core and records each one in an internal circular instruction cache. In DUP mode it replays the recorded instructions, tagged as duplicates for the downstream register remapper.
- Counts committed original and duplicate instructions and raises qed_ready at a consistency checkpoint.

Parameters:
- DEPTH, 8, instruction cache entries (power of 2, >=2)
- ADDR_W, 3, log2(DEPTH)
- CNT_W, 8, width of commit/issue counters
- INSTR_W, 32, instruction width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exec_dup  in  1  free (symbolic) request to switch to duplicate replay
- ifu_valid  in  1  fetched original instruction valid
- ifu_instr  in  INSTR_W  fetched original instruction
- ifu_ready  out  1  sequencer accepts ifu_instr
- core_valid  out  1  instruction presented to core
- core_instr  out  INSTR_W  instruction to core
- core_is_dup  out  1  presented instruction is a duplicate
- core_ready  in  1  core accepts instruction
- commit_valid  in  1  core committed one instruction this cycle
- commit_is_dup  in  1  committed instruction was a duplicate
- qed_num_orig  out  CNT_W  committed original count
- qed_num_dup  out  CNT_W  committed duplicate count
- qed_mode  out  1  0 = ORIG, 1 = DUP (registered state)
- qed_ready  out  1  consistency checkpoint reached
- q_full  out  1  cache holds DEPTH entries
- q_empty  out  1  cache holds 0 entries

Behaviour:
- Reset (synchronous, rst=1 at posedge) clears the following to 0, with state = ORIG:
  - all cache entries, address_head, address_tail, occupancy count;
  - issue counters iss_orig and iss_dup;
  - qed_num_orig, qed_num_dup, qed_ready.
- Reset mid-operation discards queued entries and counts immediately. Commits arriving in the reset cycle are ignored.
- Occupancy counter: ADDR_W+1 bits, range 0..DEPTH. q_full = (count==DEPTH); q_empty = (count==0).
- Head/tail pointers increment modulo DEPTH (natural wrap).
- ORIG state:
  - core_valid = ifu_valid & ~q_full; core_instr = ifu_instr; core_is_dup = 0.
  - ifu_ready = core_ready & ~q_full.
  - Handshake (ifu_valid & ifu_ready): write ifu_instr at tail, tail++, count++, iss_orig++.
  - Go to DUP next cycle if ~q_empty_next & (exec_dup | q_full_next). A same-cycle handshake completes first and counts.
- DUP state:
  - ifu_ready = 0; core_valid = ~q_empty; core_instr = cache[head]; core_is_dup = 1.
  - Handshake (core_valid & core_ready): head++, count--, iss_dup++.
  - When count reaches 0, return to ORIG next cycle.
  - exec_dup is ignored in DUP.
  - The popped entry is not cleared.
- Combinational outputs: core_valid, core_instr, core_is_dup and ifu_ready are combinational from state, cache and inputs. No added latency: a fetched instruction reaches the core in the same cycle.
- Commit counters:
  - commit_valid & ~commit_is_dup: qed_num_orig++.
  - commit_valid & commit_is_dup: qed_num_dup++.
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - At most one commit per cycle.
- qed_ready (registered, updated every cycle) is 1 only if all of the following hold:
  - state == ORIG and q_empty;
  - qed_num_orig == qed_num_dup and qed_num_orig != 0;
  - qed_num_orig == iss_orig and qed_num_dup == iss_dup (nothing in flight).
- Invariants for formal:
  - count == tail - head (mod DEPTH, with full distinguished by count);
  - iss_dup <= iss_orig;
  - qed_num_dup <= qed_num_orig.

Test Plan:
- Reset, then 3 original instructions (0x00100093, 0x00200113, 0x002081B3) accepted with core_ready=1 and exec_dup=0 -> count=3, tail=3, core_is_dup=0 on each, qed_mode stays 0.
- exec_dup=1 after those 3 -> qed_mode=1 next cycle; the same 3 words replayed in order with core_is_dup=1 and ifu_ready=0; ORIG resumes the cycle after the third pop.
- 3 orig commits, then 3 dup commits, with cache empty -> qed_ready=1 one cycle after the last dup commit. A fourth orig commit -> qed_ready=0 next cycle.
- Fill to DEPTH=8 with exec_dup=0 -> q_full=1, forced DUP next cycle. Replay across wrap (head 6→7→0) returns correct words. Tail wraps to 0.
- core_ready=0 for 4 cycles in DUP -> core_instr held, head unchanged. ifu_valid=1 with exec_dup=1 in the same ORIG cycle -> instruction pushed first, DUP entered next cycle.
- rst asserted mid-replay with count=5 -> next cycle count=0, qed_mode=0, both counters 0, qed_ready=0.
